// File: rtl/addsub_pkg.sv
// Shared constants for the registered adder/subtractor.
package addsub_pkg;

  localparam int   ADDSUB_WIDTH = 4;
  localparam logic OP_ADD       = 1'b0;
  localparam logic OP_SUB       = 1'b1;

endpackage : addsub_pkg

// File: rtl/full_adder.sv
// One-bit combinational full adder; the ripple chain is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/four_bit_adder_subtractor.sv
// Registered two's-complement adder/subtractor over a ripple-carry chain.
// Define ADDSUB_OVERFLOW_EN to add the registered signed-overflow output.
module four_bit_adder_subtractor
  import addsub_pkg::*;
#(
  parameter int WIDTH = ADDSUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             subtract,
  output logic [WIDTH-1:0] Result,
`ifdef ADDSUB_OVERFLOW_EN
  output logic             Cout,
  output logic             Overflow
`else
  output logic             Cout
`endif
);

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;

  // Subtraction is A + ~B + 1: invert B and feed the select in as carry-in.
  assign bb   = B ^ {WIDTH{subtract}};
  assign c[0] = subtract;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a    (A[i]),
      .b    (bb[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; reset is sampled on the clock edge (synchronous).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Result <= '0;
      Cout   <= 1'b0;
    end else begin
      Result <= s;
      Cout   <= c[WIDTH];
    end
  end

`ifdef ADDSUB_OVERFLOW_EN
  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk) begin
    if (!rst_n) Overflow <= 1'b0;
    else        Overflow <= c[WIDTH] ^ c[WIDTH-1];
  end
`endif

endmodule : four_bit_adder_subtractor

// File: tb/tb_four_bit_adder_subtractor.sv
// Self-checking bench: directed steps, scoreboard queue, 1-cycle latency.
module tb_four_bit_adder_subtractor;
  import addsub_pkg::*;

  typedef struct packed {
    logic [3:0] r;
    logic       c;
    logic       o;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic       sub;
  logic [3:0] result;
  logic       cout;
`ifdef ADDSUB_OVERFLOW_EN
  logic       overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  four_bit_adder_subtractor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a),
    .B        (b),
    .subtract (sub),
    .Result   (result),
`ifdef ADDSUB_OVERFLOW_EN
    .Cout     (cout),
    .Overflow (overflow)
`else
    .Cout     (cout)
`endif
  );

  // Reference model in arithmetic terms, independent of the adder structure.
  function automatic exp_t model(input logic [3:0] x, input logic [3:0] y,
                                 input logic s, input logic rn);
    exp_t e;
    int   ux, uy, sx, sy, sr;
    ux = int'(x);
    uy = int'(y);
    sx = (ux > 7) ? ux - 16 : ux;
    sy = (uy > 7) ? uy - 16 : uy;
    if (!rn) begin
      e = '0;
    end else if (s == OP_ADD) begin
      e.r = 4'((ux + uy) % 16);
      e.c = (ux + uy) > 15;
      sr  = sx + sy;
      e.o = (sr > 7) || (sr < -8);
    end else begin
      e.r = 4'((ux - uy + 16) % 16);
      e.c = ux >= uy;
      sr  = sx - sy;
      e.o = (sr > 7) || (sr < -8);
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one operation, push its expectation, then compare after the edge.
  task automatic step(input string tag, input logic [3:0] x, input logic [3:0] y,
                      input logic s, input logic rn);
    exp_t e;
    @(negedge clk);
    a     = x;
    b     = y;
    sub   = s;
    rst_n = rn;
    sb_q.push_back(model(x, y, s, rn));
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_queue"}, 5'd1, 5'd0);
    end else begin
      e = sb_q.pop_front();
      check(tag, {cout, result}, {e.c, e.r});
`ifdef ADDSUB_OVERFLOW_EN
      check({tag, "_ovf"}, {4'd0, overflow}, {4'd0, e.o});
`endif
    end
  endtask

  initial begin
    logic [8:0] v;
    rst_n = 1'b0;
    a = 4'd15; b = 4'd15; sub = OP_SUB;

    step("reset0", 4'd15, 4'd15, OP_SUB, 1'b0);
    step("reset1", 4'd15, 4'd15, OP_SUB, 1'b0);
    step("release", 4'd15, 4'd15, OP_SUB, 1'b1);

    step("add_5_3",  4'd5,  4'd3, OP_ADD, 1'b1);
    step("add_15_1", 4'd15, 4'd1, OP_ADD, 1'b1);
    step("sub_5_3",  4'd5,  4'd3, OP_SUB, 1'b1);
    step("sub_3_5",  4'd3,  4'd5, OP_SUB, 1'b1);
    step("sub_8_1",  4'd8,  4'd1, OP_SUB, 1'b1);

    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      if (i == 300) step("mid_reset", v[7:4], v[3:0], v[8], 1'b0);
      step("sweep", v[7:4], v[3:0], v[8], 1'b1);
    end

    for (int i = 0; i < 4; i++) begin
      step("alt_9_9", 4'd9, 4'd9, (i % 2 == 1) ? OP_SUB : OP_ADD, 1'b1);
    end

    check("queue_drained", 5'(sb_q.size()), 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_four_bit_adder_subtractor
